// File: rtl/axi_dma_engine_pkg.sv
// Shared types and constants for the AXI DMA engine S2MM command path.
package axi_dma_engine_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int AXI_4KB = 4096;

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
   } burst_desc_t;

   function automatic int clog2(input int v);
      int r;
      for (r = 0; (1 << r) < v; r++) begin
      end
      return r;
   endfunction

endpackage

// File: rtl/axi_dma_engine_burst_splitter.sv
// Splits one write command into AXI burst descriptors bounded by the
// maximum burst length and 4KB pages. One descriptor every two cycles at most.
module axi_dma_engine_burst_splitter
   import axi_dma_engine_pkg::*;
#(
   parameter int BW            = 4,
   parameter int MAX_BURST_LEN = 16
) (
   input  logic        axis_aclk,
   input  logic        axis_aresetn,
   input  logic        start,
   input  logic [31:0] start_addr,
   input  logic [23:0] start_beats,
   output logic [31:0] m_burst_addr,
   output logic [7:0]  m_burst_len,
   output logic        m_burst_valid,
   input  logic        m_burst_ready,
   output logic        done_nxt
);

   localparam int LOG_BW = clog2(BW);

   logic [31:0] cur_addr;
   logic [23:0] beats_left;
   logic [8:0]  cur_beats;
   burst_desc_t desc;
   logic [12:0] room;
   logic [23:0] beats_c;
   logic        hs;

   assign hs           = m_burst_valid & m_burst_ready;
   assign m_burst_addr = desc.addr;
   assign m_burst_len  = desc.len;
   // Beats are exhausted now, or will be once the final descriptor is taken.
   assign done_nxt     = (beats_left == '0) | (hs & (beats_left == 24'(cur_beats)));

   // Next burst size: smallest of remaining beats, burst cap and room in the 4KB page.
   always_comb begin
      room    = 13'(AXI_4KB) - {1'b0, cur_addr[11:0]};
      beats_c = beats_left;
      if (beats_c > 24'(MAX_BURST_LEN)) beats_c = 24'(MAX_BURST_LEN);
      if (beats_c > 24'(room >> LOG_BW)) beats_c = 24'(room >> LOG_BW);
   end

   // Descriptor register: load on start, present, hold until taken, then advance.
   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         cur_addr      <= '0;
         beats_left    <= '0;
         cur_beats     <= '0;
         desc          <= '0;
         m_burst_valid <= 1'b0;
      end else if (start) begin
         cur_addr      <= start_addr;
         beats_left    <= start_beats;
         m_burst_valid <= 1'b0;
      end else if (m_burst_valid) begin
         if (m_burst_ready) begin
            m_burst_valid <= 1'b0;
            cur_addr      <= cur_addr + (32'(cur_beats) << LOG_BW);
            beats_left    <= beats_left - 24'(cur_beats);
         end
      end else if (beats_left != '0) begin
         desc.addr     <= cur_addr;
         desc.len      <= 8'(beats_c - 24'd1);
         cur_beats     <= 9'(beats_c);
         m_burst_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/axi_dma_engine_s2mm_cmd_sched.sv
// S2MM command scheduler: runs one write command at a time, gating the input
// stream into the realign stage and issuing burst descriptors via the splitter.
// Optional byte-count check enabled by S2MM_CMD_SCHED_LEN_CHK_EN.
module axi_dma_engine_s2mm_cmd_sched
   import axi_dma_engine_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int MAX_BURST_LEN = 16,
   parameter int SIM_DELAY     = 1
) (
   input  logic                    axis_aclk,
   input  logic                    axis_aresetn,
   input  logic [31:0]             s_cmd_addr,
   input  logic [23:0]             s_cmd_bytes,
   input  logic                    s_cmd_valid,
   output logic                    s_cmd_ready,
   input  logic [DATA_WIDTH-1:0]   s_axis_data,
   input  logic [DATA_WIDTH/8-1:0] s_axis_keep,
   input  logic                    s_axis_last,
   input  logic                    s_axis_valid,
   output logic                    s_axis_ready,
   output logic [DATA_WIDTH-1:0]   m_axis_data,
   output logic [DATA_WIDTH/8-1:0] m_axis_keep,
   output logic                    m_axis_last,
   output logic [4:0]              m_axis_user,
   output logic                    m_axis_valid,
   input  logic                    m_axis_ready,
   output logic [31:0]             m_burst_addr,
   output logic [7:0]              m_burst_len,
   output logic                    m_burst_valid,
   input  logic                    m_burst_ready,
   output logic                    m_done_valid,
   output logic                    m_done_err
);

   localparam int BW     = DATA_WIDTH / 8;
   localparam int LOG_BW = clog2(BW);

   state_t      state;
   logic [4:0]  off_q;
   logic [23:0] bytes_q;
   logic        str_done;
   logic        run, cmd_hs, beat_acc, str_fin, brst_fin;
   logic        drain, err_nxt, zero_err;
   logic [25:0] cmd_sum;

   assign run      = (state == ST_RUN);
   assign cmd_hs   = s_cmd_valid & s_cmd_ready;
   assign beat_acc = s_axis_valid & s_axis_ready;
   assign str_fin  = str_done | (beat_acc & s_axis_last);
   assign cmd_sum  = 26'(s_cmd_addr & 32'(BW - 1)) + 26'(s_cmd_bytes) + 26'(BW - 1);

   // Stream gate: pass-through only while the current command still wants data.
   always_comb begin
      s_axis_ready = run & ~str_done & (m_axis_ready | drain);
      m_axis_valid = run & ~str_done & ~drain & s_axis_valid;
      m_axis_data  = run ? s_axis_data : '0;
      m_axis_keep  = run ? s_axis_keep : '0;
      m_axis_last  = run ? s_axis_last : 1'b0;
      m_axis_user  = run ? off_q : 5'd0;
   end

`ifdef S2MM_CMD_SCHED_LEN_CHK_EN
   logic [25:0] byte_cnt, byte_cnt_nxt;

   assign byte_cnt_nxt = byte_cnt + (beat_acc ? 26'($countones(s_axis_keep)) : 26'd0);
   assign err_nxt      = (byte_cnt_nxt != 26'(bytes_q));
   assign zero_err     = 1'b1;

   // Count delivered bytes; once the command is satisfied early, swallow beats up to last.
   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         byte_cnt <= '0;
         drain    <= 1'b0;
      end else if (state == ST_IDLE) begin
         byte_cnt <= '0;
         drain    <= 1'b0;
      end else if (run) begin
         byte_cnt <= byte_cnt_nxt;
         if (beat_acc & ~s_axis_last & (byte_cnt_nxt >= 26'(bytes_q))) drain <= 1'b1;
      end
   end
`else
   assign drain    = 1'b0;
   assign err_nxt  = 1'b0;
   assign zero_err = 1'b0;
`endif

   axi_dma_engine_burst_splitter #(
      .BW            (BW),
      .MAX_BURST_LEN (MAX_BURST_LEN)
   ) u_splitter (
      .axis_aclk     (axis_aclk),
      .axis_aresetn  (axis_aresetn),
      .start         (cmd_hs & (s_cmd_bytes != '0)),
      .start_addr    (s_cmd_addr & ~32'(BW - 1)),
      .start_beats   (24'(cmd_sum >> LOG_BW)),
      .m_burst_addr  (m_burst_addr),
      .m_burst_len   (m_burst_len),
      .m_burst_valid (m_burst_valid),
      .m_burst_ready (m_burst_ready),
      .done_nxt      (brst_fin)
   );

   // Command FSM: accept, run until stream and bursts both finish, pulse done.
   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         state        <= ST_IDLE;
         s_cmd_ready  <= 1'b0;
         m_done_valid <= 1'b0;
         m_done_err   <= 1'b0;
         off_q        <= '0;
         bytes_q      <= '0;
         str_done     <= 1'b0;
      end else begin
         m_done_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               s_cmd_ready <= 1'b1;
               if (cmd_hs) begin
                  s_cmd_ready <= 1'b0;
                  off_q       <= 5'(s_cmd_addr & 32'(BW - 1));
                  bytes_q     <= s_cmd_bytes;
                  str_done    <= 1'b0;
                  if (s_cmd_bytes == '0) begin
                     state        <= ST_DONE;
                     m_done_valid <= 1'b1;
                     m_done_err   <= zero_err;
                  end else begin
                     state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               str_done <= str_fin;
               if (str_fin & brst_fin) begin
                  state        <= ST_DONE;
                  m_done_valid <= 1'b1;
                  m_done_err   <= err_nxt;
               end
            end
            ST_DONE: begin
               state       <= ST_IDLE;
               s_cmd_ready <= 1'b1;
               m_done_err  <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_dma_engine_s2mm_cmd_sched.sv
// Bench for the S2MM command scheduler (DATA_WIDTH=32, MAX_BURST_LEN=16).
module tb_axi_dma_engine_s2mm_cmd_sched;

   localparam int DW = 32;
   localparam int BW = 4;

   logic          axis_aclk = 1'b0;
   logic          axis_aresetn = 1'b0;
   logic [31:0]   s_cmd_addr = '0;
   logic [23:0]   s_cmd_bytes = '0;
   logic          s_cmd_valid = 1'b0;
   logic          s_cmd_ready;
   logic [DW-1:0] s_axis_data = '0;
   logic [BW-1:0] s_axis_keep = '0;
   logic          s_axis_last = 1'b0;
   logic          s_axis_valid = 1'b0;
   logic          s_axis_ready;
   logic [DW-1:0] m_axis_data;
   logic [BW-1:0] m_axis_keep;
   logic          m_axis_last;
   logic [4:0]    m_axis_user;
   logic          m_axis_valid;
   logic          m_axis_ready = 1'b0;
   logic [31:0]   m_burst_addr;
   logic [7:0]    m_burst_len;
   logic          m_burst_valid;
   logic          m_burst_ready = 1'b0;
   logic          m_done_valid;
   logic          m_done_err;

   always #5 axis_aclk = ~axis_aclk;

   axi_dma_engine_s2mm_cmd_sched #(
      .DATA_WIDTH(DW), .MAX_BURST_LEN(16), .SIM_DELAY(1)
   ) dut (
      .axis_aclk(axis_aclk), .axis_aresetn(axis_aresetn),
      .s_cmd_addr(s_cmd_addr), .s_cmd_bytes(s_cmd_bytes),
      .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
      .s_axis_data(s_axis_data), .s_axis_keep(s_axis_keep),
      .s_axis_last(s_axis_last), .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready),
      .m_axis_data(m_axis_data), .m_axis_keep(m_axis_keep), .m_axis_last(m_axis_last),
      .m_axis_user(m_axis_user), .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready),
      .m_burst_addr(m_burst_addr), .m_burst_len(m_burst_len),
      .m_burst_valid(m_burst_valid), .m_burst_ready(m_burst_ready),
      .m_done_valid(m_done_valid), .m_done_err(m_done_err)
   );

   typedef logic [41:0] beat_t;   // {data, keep, last, user}
   typedef logic [39:0] brst_t;   // {addr, len}

   typedef struct {
      logic [31:0] addr;
      logic [23:0] bytes;
      int          sbeats;
      logic [3:0]  lkeep;
      int          bhold;
      int          rdy;
      int          nb;
      brst_t       b[4];
      logic        err_chk;
   } vec_t;

   int    n_cmp = 0;
   int    n_err = 0;
   beat_t got_beats[$];
   beat_t exp_beats[$];
   brst_t got_bursts[$];
   brst_t exp_bursts[$];
   int    done_cnt = 0;
   logic  done_err_seen = 1'b0;
   int    rdy_pct = 100;
   int    brdy_pct = 100;
   int    bhold = 0;
   logic  prev_bv = 1'b0;
   logic  prev_br = 1'b0;
   brst_t prev_b = '0;
   vec_t  vt[7];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: record handshakes mid-cycle and check descriptor stability under backpressure.
   initial forever begin
      @(negedge axis_aclk);
      if (axis_aresetn) begin
         if (m_axis_valid && m_axis_ready)
            got_beats.push_back({m_axis_data, m_axis_keep, m_axis_last, m_axis_user});
         if (m_burst_valid && m_burst_ready)
            got_bursts.push_back({m_burst_addr, m_burst_len});
         if (prev_bv && !prev_br) begin
            chk("burst_hold_valid", 64'(m_burst_valid), 64'd1);
            chk("burst_hold_desc", 64'({m_burst_addr, m_burst_len}), 64'(prev_b));
         end
         if (m_done_valid) begin
            done_cnt++;
            done_err_seen = m_done_err;
         end
      end
      prev_bv = m_burst_valid & axis_aresetn;
      prev_br = m_burst_ready;
      prev_b  = {m_burst_addr, m_burst_len};
   end

   initial forever begin
      @(posedge axis_aclk); #1;
      m_axis_ready = ($urandom_range(0, 99) < rdy_pct);
   end

   initial forever begin
      @(posedge axis_aclk); #1;
      if (bhold > 0 && m_burst_valid) begin
         m_burst_ready = 1'b0;
         bhold--;
      end else begin
         m_burst_ready = ($urandom_range(0, 99) < brdy_pct);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Reference burst list from the address/length rules, plain arithmetic.
   function automatic void model_bursts(input logic [31:0] addr, input logic [23:0] bytes);
      int unsigned a, rem, n, room;
      exp_bursts.delete();
      a   = addr & ~32'd3;
      rem = ((addr % 4) + bytes + 3) / 4;
      while (rem > 0) begin
         room = (4096 - (a % 4096)) / 4;
         n = rem;
         if (n > 16) n = 16;
         if (n > room) n = room;
         exp_bursts.push_back({a, 8'(n - 1)});
         a   = a + n * 4;
         rem = rem - n;
      end
   endfunction

   function automatic vec_t mk(input logic [31:0] addr, input logic [23:0] bytes, input int sbeats,
                               input logic [3:0] lkeep, input int bh, input int rdy, input int nb,
                               input brst_t b0, input brst_t b1, input brst_t b2, input brst_t b3,
                               input logic ec);
      vec_t v;
      v.addr = addr; v.bytes = bytes; v.sbeats = sbeats; v.lkeep = lkeep; v.bhold = bh;
      v.rdy = rdy; v.nb = nb; v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.err_chk = ec;
      return v;
   endfunction

   task automatic wait_cmd_ready();
      int t = 0;
      while (!s_cmd_ready && t < 100) begin
         @(posedge axis_aclk); #1;
         t++;
      end
      chk("cmd_ready", 64'(s_cmd_ready), 64'd1);
   endtask

   task automatic run_cmd(input logic [31:0] addr, input logic [23:0] bytes,
                          input int sbeats, input logic [3:0] lkeep);
      int   t;
      logic acc;
      got_beats.delete(); got_bursts.delete(); exp_beats.delete();
      done_cnt = 0; done_err_seen = 1'b0;
      wait_cmd_ready();
      s_cmd_addr = addr; s_cmd_bytes = bytes; s_cmd_valid = 1'b1;
      @(posedge axis_aclk); #1;
      s_cmd_valid = 1'b0;
      for (int i = 0; i < sbeats; i++) begin
         s_axis_data  = $urandom;
         s_axis_keep  = (i == sbeats - 1) ? lkeep : 4'hF;
         s_axis_last  = (i == sbeats - 1);
         s_axis_valid = 1'b1;
         exp_beats.push_back({s_axis_data, s_axis_keep, s_axis_last, 5'(addr % 4)});
         t = 0; acc = 1'b0;
         while (!acc && t < 1000) begin
            @(negedge axis_aclk);
            acc = s_axis_ready;
            @(posedge axis_aclk); #1;
            t++;
         end
         if (!acc) begin
            chk("beat_accept", 64'(acc), 64'd1);
            break;
         end
      end
      s_axis_valid = 1'b0; s_axis_last = 1'b0;
      t = 0;
      while (done_cnt == 0 && t < 2000) begin
         @(posedge axis_aclk); #1;
         t++;
      end
      repeat (4) @(posedge axis_aclk);
      #1;
      chk("done_pulses", 64'(done_cnt), 64'd1);
      chk("beat_count", 64'(got_beats.size()), 64'(exp_beats.size()));
      for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++)
         chk("beat", 64'(got_beats[i]), 64'(exp_beats[i]));
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_ctl"}, 64'({s_cmd_ready, s_axis_ready, m_axis_valid, m_burst_valid,
                               m_done_valid, m_done_err, m_axis_last}), 64'd0);
      chk({tag, "_burst"}, 64'({m_burst_addr, m_burst_len}), 64'd0);
      chk({tag, "_stream"}, 64'({m_axis_data, m_axis_keep, m_axis_user}), 64'd0);
   endtask

   initial begin
      logic        exp_err;
      logic [31:0] ra;
      logic [23:0] rb;
      int          t, rem;

      vt[0] = mk(32'h1000,  64, 16, 4'hF, 0, 100, 1, {32'h1000, 8'd15}, '0, '0, '0, 1'b0);
      vt[1] = mk(32'h1002,   8,  2, 4'hF, 0, 100, 1, {32'h1000, 8'd2},  '0, '0, '0, 1'b0);
      vt[2] = mk(32'h0FF8,  32,  8, 4'hF, 0, 100, 2, {32'h0FF8, 8'd1}, {32'h1000, 8'd5}, '0, '0, 1'b0);
      vt[3] = mk(32'h0000, 200, 50, 4'hF, 5,  60, 4, {32'h0000, 8'd15}, {32'h0040, 8'd15},
                 {32'h0080, 8'd15}, {32'h00C0, 8'd1}, 1'b0);
      vt[4] = mk(32'h1000,  16,  3, 4'hF, 0, 100, 1, {32'h1000, 8'd3}, '0, '0, '0, 1'b1);
      vt[5] = mk(32'h1000,  16,  4, 4'hF, 0, 100, 1, {32'h1000, 8'd3}, '0, '0, '0, 1'b0);
      vt[6] = mk(32'h2000,   0,  0, 4'hF, 0, 100, 0, '0, '0, '0, '0, 1'b1);

      repeat (3) @(posedge axis_aclk);
      #1;
      chk_idle_outputs("reset");
      @(negedge axis_aclk);
      axis_aresetn = 1'b1;

      // Directed vectors from the table.
      for (int v = 0; v < 7; v++) begin
         rdy_pct = vt[v].rdy; brdy_pct = 100; bhold = vt[v].bhold;
         run_cmd(vt[v].addr, vt[v].bytes, vt[v].sbeats, vt[v].lkeep);
         chk($sformatf("v%0d_burst_count", v), 64'(got_bursts.size()), 64'(vt[v].nb));
         for (int i = 0; i < vt[v].nb && i < got_bursts.size(); i++)
            chk($sformatf("v%0d_burst%0d", v, i), 64'(got_bursts[i]), 64'(vt[v].b[i]));
`ifdef S2MM_CMD_SCHED_LEN_CHK_EN
         exp_err = vt[v].err_chk;
`else
         exp_err = 1'b0;
`endif
         chk($sformatf("v%0d_done_err", v), 64'(done_err_seen), 64'(exp_err));
      end

      // Random commands against the reference model.
      for (int r = 0; r < 24; r++) begin
         ra = $urandom & 32'h3FFF;
         if (r % 3 == 0) ra = 32'h1000 * $urandom_range(1, 3) - $urandom_range(1, 80);
         rb  = 24'($urandom_range(1, 260));
         rem = int'(rb % 4);
         rdy_pct = $urandom_range(30, 100); brdy_pct = $urandom_range(20, 100); bhold = 0;
         run_cmd(ra, rb, int'((rb + 3) / 4), (rem == 0) ? 4'hF : 4'((1 << rem) - 1));
         model_bursts(ra, rb);
         chk("rnd_burst_count", 64'(got_bursts.size()), 64'(exp_bursts.size()));
         for (int i = 0; i < exp_bursts.size() && i < got_bursts.size(); i++)
            chk("rnd_burst", 64'(got_bursts[i]), 64'(exp_bursts[i]));
         chk("rnd_done_err", 64'(done_err_seen), 64'd0);
      end

      // Reset in the middle of a command, after two bursts have gone out.
      rdy_pct = 100; brdy_pct = 100; bhold = 0;
      got_bursts.delete();
      wait_cmd_ready();
      s_cmd_addr = 32'h0; s_cmd_bytes = 24'd200; s_cmd_valid = 1'b1;
      @(posedge axis_aclk); #1;
      s_cmd_valid = 1'b0;
      t = 0;
      while (got_bursts.size() < 2 && t < 200) begin
         @(posedge axis_aclk); #1;
         t++;
      end
      chk("mid_bursts_seen", 64'(got_bursts.size() >= 2), 64'd1);
      @(posedge axis_aclk); #2;
      axis_aresetn = 1'b0;
      #1;
      chk_idle_outputs("async_reset");
      @(negedge axis_aclk);
      axis_aresetn = 1'b1;

      rdy_pct = 80;
      run_cmd(vt[0].addr, vt[0].bytes, vt[0].sbeats, vt[0].lkeep);
      chk("post_reset_burst_count", 64'(got_bursts.size()), 64'd1);
      if (got_bursts.size() > 0)
         chk("post_reset_burst", 64'(got_bursts[0]), 64'(vt[0].b[0]));
      chk("post_reset_done_err", 64'(done_err_seen), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
